wash_stage_sequencer: RTL and testbench

WASH_STAGE_SEQUENCER -- requirements
Module: wash_stage_sequencer

---
 rtl/wash_pkg.sv | 30 +++
 rtl/wash_stage_timer.sv | 28 ++
 rtl/wash_stage_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_wash_stage_sequencer.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wash_pkg.sv
// Shared stage codes and stage-class helpers for the wash sequencer.
// No logic, no latency; no flow control.
package wash_pkg;

    typedef logic [3:0] stage_t;

    localparam stage_t ST_IDLE   = 4'd0;
    localparam stage_t ST_LOCK   = 4'd1;
    localparam stage_t ST_FILL   = 4'd2;
    localparam stage_t ST_WASH   = 4'd3;
    localparam stage_t ST_DRAIN  = 4'd4;
    localparam stage_t ST_RFILL  = 4'd5;
    localparam stage_t ST_RINSE  = 4'd6;
    localparam stage_t ST_RDRAIN = 4'd7;
    localparam stage_t ST_SPIN   = 4'd8;
    localparam stage_t ST_DONE   = 4'd9;
    localparam stage_t ST_PAUSED = 4'd10;
    localparam stage_t ST_FAULT  = 4'd11;

    // Door held locked (and machine busy) from LOCK through PAUSED.
    function automatic logic stage_locked(input stage_t s);
        return (s >= ST_LOCK) && (s <= ST_PAUSED);
    endfunction

    // Stages that run the timer and may be paused.
    function automatic logic stage_timed(input stage_t s);
        return (s >= ST_FILL) && (s <= ST_SPIN);
    endfunction

endpackage

// File: rtl/wash_stage_timer.sv
// Tick down-counter: load, decrement on tick while nonzero, freeze, zero flag.
// Load takes effect on the next clock; zero reflects the registered count.
// No backpressure; freeze holds the count regardless of tick.
module wash_stage_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        freeze,
    output logic        zero
);

    logic [15:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 16'd0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && !freeze && (count != 16'd0)) begin
            count <= count - 16'd1;
        end
    end

    assign zero = (count == 16'd0);

endmodule

// File: rtl/wash_stage_sequencer.sv
// Washing-machine stage sequencer; optional second rinse pass with WASH_EXTRA_RINSE_EN.
// Outputs registered: one clock from input to stage/actuator change.
// No backpressure; pause freezes the stage timer, door open latches FAULT until reset.
module wash_stage_sequencer
    import wash_pkg::*;
#(
    parameter logic [15:0] WASH_T  = 16'd600,
    parameter logic [15:0] RINSE_T = 16'd300,
    parameter logic [15:0] SPIN_T  = 16'd240,
    parameter logic [15:0] FILL_TO = 16'd120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       pause,
    input  logic       door_closed,
    input  logic       level_full,
    input  logic       level_empty,
    output logic [3:0] stage,
    output logic       valve_enable,
    output logic       drain_enable,
    output logic       motor_on,
    output logic       spin_on,
    output logic       door_lock,
    output logic       busy,
    output logic       done,
    output logic       fault
);

    stage_t      stage_q;
    stage_t      stage_nxt;
    stage_t      saved_q;
    stage_t      saved_nxt;
    stage_t      run_nxt;
    logic        entry_q;
    logic        t_load;
    logic [15:0] t_val;
    logic        t_freeze;
    logic        t_zero;

`ifdef WASH_EXTRA_RINSE_EN
    logic pass_q;
    logic pass_nxt;
`endif

    wash_stage_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .load     (t_load),
        .load_val (t_val),
        .freeze   (t_freeze),
        .zero     (t_zero)
    );

    // Where a running stage goes when neither door nor pause intervenes.
    // Level sensors are tested before the timeout so they win a tie.
    always_comb begin
        run_nxt = stage_q;
        case (stage_q)
            ST_FILL: begin
                if (level_full)  run_nxt = ST_WASH;
                else if (t_zero) run_nxt = ST_FAULT;
            end
            ST_WASH: begin
                if (t_zero) run_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (level_empty) run_nxt = ST_RFILL;
                else if (t_zero) run_nxt = ST_FAULT;
            end
            ST_RFILL: begin
                if (level_full)  run_nxt = ST_RINSE;
                else if (t_zero) run_nxt = ST_FAULT;
            end
            ST_RINSE: begin
                if (t_zero) run_nxt = ST_RDRAIN;
            end
            ST_RDRAIN: begin
`ifdef WASH_EXTRA_RINSE_EN
                if (level_empty) run_nxt = pass_q ? ST_SPIN : ST_RFILL;
                else if (t_zero) run_nxt = ST_FAULT;
`else
                if (level_empty) run_nxt = ST_SPIN;
                else if (t_zero) run_nxt = ST_FAULT;
`endif
            end
            ST_SPIN: begin
                if (t_zero) run_nxt = ST_DONE;
            end
            default: run_nxt = stage_q;
        endcase
    end

    always_comb begin
        stage_nxt = stage_q;
        saved_nxt = saved_q;
`ifdef WASH_EXTRA_RINSE_EN
        pass_nxt  = pass_q;
`endif
        case (stage_q)
            ST_IDLE: begin
                if (start && door_closed) stage_nxt = ST_LOCK;
            end
            ST_LOCK: begin
                stage_nxt = door_closed ? ST_FILL : ST_FAULT;
`ifdef WASH_EXTRA_RINSE_EN
                pass_nxt  = 1'b0;
`endif
            end
            ST_FILL, ST_WASH, ST_DRAIN, ST_RFILL, ST_RINSE, ST_RDRAIN, ST_SPIN: begin
                if (!door_closed) begin
                    stage_nxt = ST_FAULT;
                end else if (pause) begin
                    stage_nxt = ST_PAUSED;
                    saved_nxt = stage_q;
                end else begin
                    stage_nxt = run_nxt;
                end
            end
            ST_DONE: begin
                stage_nxt = door_closed ? ST_IDLE : ST_FAULT;
            end
            ST_PAUSED: begin
                if (!door_closed) stage_nxt = ST_FAULT;
                else if (!pause)  stage_nxt = saved_q;
            end
            ST_FAULT: stage_nxt = ST_FAULT;
            default:  stage_nxt = ST_FAULT;
        endcase
`ifdef WASH_EXTRA_RINSE_EN
        if ((stage_q == ST_RDRAIN) && (stage_nxt == ST_RFILL)) pass_nxt = 1'b1;
`endif
    end

    // Load on a fresh entry only; a resume from PAUSED keeps the frozen count.
    assign t_load   = (stage_nxt != stage_q) && (stage_q != ST_PAUSED) && stage_timed(stage_nxt);
    assign t_freeze = entry_q || (stage_q == ST_PAUSED);

    always_comb begin
        case (stage_nxt)
            ST_FILL, ST_DRAIN, ST_RFILL, ST_RDRAIN: t_val = FILL_TO;
            ST_WASH:  t_val = WASH_T;
            ST_RINSE: t_val = RINSE_T;
            ST_SPIN:  t_val = SPIN_T;
            default:  t_val = 16'd0;
        endcase
    end

    // Outputs decode the next stage so they line up with the stage register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q      <= ST_IDLE;
            saved_q      <= ST_IDLE;
            entry_q      <= 1'b0;
            valve_enable <= 1'b0;
            drain_enable <= 1'b0;
            motor_on     <= 1'b0;
            spin_on      <= 1'b0;
            door_lock    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            fault        <= 1'b0;
        end else begin
            stage_q      <= stage_nxt;
            saved_q      <= saved_nxt;
            entry_q      <= t_load;
            valve_enable <= (stage_nxt == ST_FILL) || (stage_nxt == ST_RFILL);
            drain_enable <= (stage_nxt == ST_DRAIN) || (stage_nxt == ST_RDRAIN) ||
                            (stage_nxt == ST_SPIN);
            motor_on     <= (stage_nxt == ST_WASH) || (stage_nxt == ST_RINSE);
            spin_on      <= (stage_nxt == ST_SPIN);
            door_lock    <= stage_locked(stage_nxt);
            busy         <= stage_locked(stage_nxt);
            done         <= (stage_nxt == ST_DONE);
            fault        <= (stage_nxt == ST_FAULT);
        end
    end

`ifdef WASH_EXTRA_RINSE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pass_q <= 1'b0;
        else       pass_q <= pass_nxt;
    end
`endif

    assign stage = stage_q;

endmodule

// File: tb/tb_wash_stage_sequencer.sv
// Randomized bench for wash_stage_sequencer with a plant model and stage-visit recorder.
`timescale 1ns/1ps
module tb_wash_stage_sequencer;

    localparam int WT = 3;
    localparam int RT = 2;
    localparam int SPT = 2;
    localparam int FT = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       door_closed = 1'b1;
    logic       level_full = 1'b0;
    logic       level_empty = 1'b0;
    logic [3:0] stage;
    logic       valve_enable, drain_enable, motor_on, spin_on;
    logic       door_lock, busy, done, fault;

    int errors = 0;
    int checks = 0;

    int         tphase = 0;
    int         visit_ticks = 0;
    logic [3:0] last_stage = 4'd0;
    bit         entry;
    bit         mon_en = 1'b0;
    bit         plant_en = 1'b0;
    int         fill_delay = 2;
    int         drain_delay = 1;
    int         seq_q[$];
    int         dur_q[$];
    int         done_cnt = 0;
    int         act_bad = 0;

    wash_stage_sequencer #(
        .WASH_T (16'd3),
        .RINSE_T(16'd2),
        .SPIN_T (16'd2),
        .FILL_TO(16'd4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .start       (start),
        .pause       (pause),
        .door_closed (door_closed),
        .level_full  (level_full),
        .level_empty (level_empty),
        .stage       (stage),
        .valve_enable(valve_enable),
        .drain_enable(drain_enable),
        .motor_on    (motor_on),
        .spin_on     (spin_on),
        .door_lock   (door_lock),
        .busy        (busy),
        .done        (done),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    // Timebase, level-sensor plant and stage-visit recorder, 1ns after each edge.
    initial begin : env
        logic [7:0] exp_act;
        int s;
        forever begin
            @(posedge clk);
            #1;
            entry = (stage != last_stage) && (last_stage != 4'd10);
            if (stage != last_stage) begin
                if (mon_en) begin
                    seq_q.push_back(int'(stage));
                    dur_q.push_back(visit_ticks);
                end
                visit_ticks = 0;
            end
            last_stage = stage;
            tick = (tphase == 0);
            tphase = (tphase + 1) % 4;
            if (tick && !entry) visit_ticks++;
            level_full  = plant_en && (stage == 4'd2 || stage == 4'd5) && (visit_ticks >= fill_delay);
            level_empty = plant_en && (stage == 4'd4 || stage == 4'd7) && (visit_ticks >= drain_delay);
            if (mon_en) begin
                s = int'(stage);
                if (done) done_cnt++;
                exp_act = {(s == 2 || s == 5), (s == 4 || s == 7 || s == 8), (s == 3 || s == 6),
                           (s == 8), (s >= 1 && s <= 10), (s >= 1 && s <= 10), (s == 9), (s == 11)};
                if ({valve_enable, drain_enable, motor_on, spin_on, door_lock, busy, done, fault} !== exp_act)
                    act_bad++;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_for(input logic [3:0] s, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (stage == s) begin
                ok = 1'b1;
                break;
            end
            cyc(1);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(1);
    endtask

    task automatic start_monitor();
        seq_q.delete();
        dur_q.delete();
        seq_q.push_back(int'(stage));
        done_cnt = 0;
        act_bad = 0;
        mon_en = 1'b1;
    endtask

    // Expected visit list and per-visit tick counts for one undisturbed cycle.
    task automatic build_cycle(input int fd, input int dd, output int es[$], output int ed[$]);
        es = '{0, 1, 2, 3, 4, 5, 6, 7};
        ed = '{-1, 0, fd, WT, dd, fd, RT, dd};
`ifdef WASH_EXTRA_RINSE_EN
        es.push_back(5); es.push_back(6); es.push_back(7);
        ed.push_back(fd); ed.push_back(RT); ed.push_back(dd);
`endif
        es.push_back(8); es.push_back(9); es.push_back(0);
        ed.push_back(SPT); ed.push_back(0);
    endtask

    task automatic test_reset();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (stage !== 4'd0) begin errors++; $display("FAIL reset_async_stage: got %0d want 0", stage); end
        checks++;
        if ({valve_enable, drain_enable, motor_on, spin_on, door_lock, busy, done, fault} !== 8'd0) begin
            errors++; $display("FAIL reset_async_outputs: got %b want 00000000",
                {valve_enable, drain_enable, motor_on, spin_on, door_lock, busy, done, fault});
        end
        cyc(2);
        reset = 1'b0;
        cyc(3);
        checks++;
        if (stage !== 4'd0) begin errors++; $display("FAIL reset_release_stage: got %0d want 0", stage); end
        checks++;
        if ({valve_enable, drain_enable, motor_on, spin_on, door_lock, busy, done, fault} !== 8'd0) begin
            errors++; $display("FAIL reset_release_outputs: got %b want 00000000",
                {valve_enable, drain_enable, motor_on, spin_on, door_lock, busy, done, fault});
        end
    endtask

    task automatic test_full_cycle();
        bit ok;
        int es[$];
        int ed[$];
        int rf;
        for (int it = 0; it < 4; it++) begin
            fill_delay  = (it == 0) ? 2 : int'($urandom_range(1, 3));
            drain_delay = (it == 0) ? 1 : int'($urandom_range(1, 3));
            plant_en = 1'b1;
            cyc(int'($urandom_range(0, 5)));
            if (it == 1) begin
                door_closed = 1'b0;
                pulse_start();
                cyc(2);
                checks++;
                if (stage !== 4'd0) begin errors++; $display("FAIL start_door_open: stage %0d want 0", stage); end
                door_closed = 1'b1;
            end
            start_monitor();
            pulse_start();
            wait_for(4'd9, 400, ok);
            cyc(1);
            checks++;
            if (!ok || stage !== 4'd0) begin
                errors++; $display("FAIL cycle_%0d_complete: reached_done=%0d stage=%0d want 1,0", it, ok, stage);
            end
            mon_en = 1'b0;
            build_cycle(fill_delay, drain_delay, es, ed);
            checks++;
            if (seq_q.size() != es.size()) begin
                errors++; $display("FAIL cycle_%0d_len: got %0d visits want %0d", it, seq_q.size(), es.size());
            end
            for (int i = 0; i < es.size() && i < seq_q.size(); i++) begin
                checks++;
                if (seq_q[i] != es[i]) begin
                    errors++; $display("FAIL cycle_%0d_seq[%0d]: got %0d want %0d", it, i, seq_q[i], es[i]);
                end
            end
            for (int i = 0; i < ed.size() && i < dur_q.size(); i++) begin
                if (ed[i] >= 0) begin
                    checks++;
                    if (dur_q[i] != ed[i]) begin
                        errors++; $display("FAIL cycle_%0d_ticks[%0d]: got %0d want %0d", it, i, dur_q[i], ed[i]);
                    end
                end
            end
            rf = 0;
            foreach (seq_q[i]) if (seq_q[i] == 5) rf++;
            checks++;
`ifdef WASH_EXTRA_RINSE_EN
            if (rf != 2) begin errors++; $display("FAIL cycle_%0d_rfill_visits: got %0d want 2", it, rf); end
`else
            if (rf != 1) begin errors++; $display("FAIL cycle_%0d_rfill_visits: got %0d want 1", it, rf); end
`endif
            checks++;
            if (done_cnt != 1) begin errors++; $display("FAIL cycle_%0d_done_pulses: got %0d want 1", it, done_cnt); end
            checks++;
            if (act_bad != 0) begin errors++; $display("FAIL cycle_%0d_actuators: %0d bad cycles want 0", it, act_bad); end
        end
    endtask

    task automatic test_fill_timeout();
        bit ok;
        int bad;
        fill_delay = 99;
        plant_en = 1'b1;
        start_monitor();
        pulse_start();
        wait_for(4'd11, 200, ok);
        mon_en = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL timeout_reach: stage %0d want 11", stage); end
        checks++;
        if (seq_q.size() != 4 || seq_q[2] != 2 || seq_q[3] != 11) begin
            errors++; $display("FAIL timeout_seq: %0d visits, last %0d want 4 visits ending 2,11",
                seq_q.size(), (seq_q.size() > 0) ? seq_q[seq_q.size()-1] : -1);
        end
        checks++;
        if (dur_q.size() < 3 || dur_q[2] != FT) begin
            errors++; $display("FAIL timeout_ticks: got %0d want %0d", (dur_q.size() > 2) ? dur_q[2] : -1, FT);
        end
        checks++;
        if ({fault, valve_enable, door_lock, busy} !== 4'b1000) begin
            errors++; $display("FAIL timeout_outputs: fault,valve,lock,busy=%b want 1000",
                {fault, valve_enable, door_lock, busy});
        end
        bad = 0;
        for (int i = 0; i < 24; i++) begin
            start = (i % 6 == 0);
            cyc(1);
            if (stage !== 4'd11 || fault !== 1'b1 || valve_enable !== 1'b0) bad++;
        end
        start = 1'b0;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL timeout_sticky: %0d bad cycles want 0", bad); end
        do_reset();
        checks++;
        if (stage !== 4'd0 || fault !== 1'b0) begin
            errors++; $display("FAIL timeout_clear: stage=%0d fault=%0d want 0,0", stage, fault);
        end
    endtask

    task automatic test_pause();
        bit ok;
        int es[$];
        int n;
        fill_delay = 2;
        drain_delay = 1;
        plant_en = 1'b1;
        start_monitor();
        pulse_start();
        n = 0;
        while (!(stage == 4'd3 && tick && visit_ticks == 1) && n < 100) begin cyc(1); n++; end
        cyc(1);
        pause = 1'b1;
        cyc(1);
        checks++;
        if (stage !== 4'd10) begin errors++; $display("FAIL pause_enter: stage %0d want 10", stage); end
        cyc(39);
        checks++;
        if ({stage, motor_on, valve_enable, drain_enable, spin_on, door_lock, busy} !== {4'd10, 6'b000011}) begin
            errors++; $display("FAIL pause_hold: stage=%0d motor,valve,drain,spin,lock,busy=%b want 10,000011",
                stage, {motor_on, valve_enable, drain_enable, spin_on, door_lock, busy});
        end
        pause = 1'b0;
        n = 0;
        while (!(stage == 4'd6 && tick && visit_ticks == RT) && n < 200) begin cyc(1); n++; end
        cyc(1);
        checks++;
        if (stage !== 4'd6) begin errors++; $display("FAIL pause_expiry_setup: stage %0d want 6", stage); end
        pause = 1'b1;
        cyc(1);
        checks++;
        if (stage !== 4'd10) begin errors++; $display("FAIL pause_beats_expiry: stage %0d want 10", stage); end
        cyc(3);
        pause = 1'b0;
        wait_for(4'd9, 400, ok);
        cyc(1);
        mon_en = 1'b0;
        checks++;
        if (!ok || stage !== 4'd0) begin errors++; $display("FAIL pause_complete: ok=%0d stage=%0d want 1,0", ok, stage); end
        es = '{0, 1, 2, 3, 10, 3, 4, 5, 6, 10, 6, 7};
        for (int i = 0; i < es.size(); i++) begin
            checks++;
            if (i >= seq_q.size() || seq_q[i] != es[i]) begin
                errors++; $display("FAIL pause_seq[%0d]: got %0d want %0d", i, (i < seq_q.size()) ? seq_q[i] : -1, es[i]);
            end
        end
        checks++;
        if (dur_q.size() < 11 || dur_q[4] != 10 || dur_q[5] != 2 || dur_q[10] != 0) begin
            errors++; $display("FAIL pause_ticks: paused=%0d wash_resumed=%0d rinse_resumed=%0d want 10,2,0",
                (dur_q.size() > 4) ? dur_q[4] : -1, (dur_q.size() > 5) ? dur_q[5] : -1,
                (dur_q.size() > 10) ? dur_q[10] : -1);
        end
        checks++;
        if (done_cnt != 1 || act_bad != 0) begin
            errors++; $display("FAIL pause_outputs: done=%0d bad=%0d want 1,0", done_cnt, act_bad);
        end
    endtask

    task automatic test_door_open();
        bit ok;
        int bad;
        fill_delay = int'($urandom_range(1, 3));
        drain_delay = int'($urandom_range(1, 3));
        plant_en = 1'b1;
        pulse_start();
        wait_for(4'd6, 300, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL door_setup: stage %0d want 6", stage); end
        door_closed = 1'b0;
        cyc(1);
        checks++;
        if ({stage, door_lock, fault, motor_on} !== {4'd11, 3'b010}) begin
            errors++; $display("FAIL door_fault: stage=%0d lock,fault,motor=%b want 11,010",
                stage, {door_lock, fault, motor_on});
        end
        door_closed = 1'b1;
        pulse_start();
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            if (stage !== 4'd11 || busy !== 1'b0 || door_lock !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL door_start_ignored: %0d bad cycles want 0", bad); end
        do_reset();
    endtask

    task automatic test_reset_in_spin();
        bit ok;
        int bad;
        fill_delay = 1;
        drain_delay = 1;
        plant_en = 1'b1;
        pulse_start();
        wait_for(4'd8, 400, ok);
        checks++;
        if (!ok || spin_on !== 1'b1) begin errors++; $display("FAIL spin_setup: stage=%0d spin=%0d want 8,1", stage, spin_on); end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({stage, valve_enable, drain_enable, motor_on, spin_on, door_lock, busy, done, fault} !== 12'd0) begin
            errors++; $display("FAIL spin_reset_async: stage=%0d outs=%b want 0,00000000", stage,
                {valve_enable, drain_enable, motor_on, spin_on, door_lock, busy, done, fault});
        end
        cyc(2);
        reset = 1'b0;
        plant_en = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            level_full = 1'($urandom_range(0, 1));
            level_empty = 1'($urandom_range(0, 1));
            pause = 1'($urandom_range(0, 1));
            if (stage !== 4'd0 || {valve_enable, drain_enable, motor_on, spin_on, door_lock} !== 5'd0) bad++;
        end
        pause = 1'b0;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL spin_reset_quiet: %0d bad cycles want 0", bad); end
    endtask

    initial begin : main
        test_reset();
        test_full_cycle();
        test_fill_timeout();
        test_pause();
        test_door_open();
        test_reset_in_spin();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
